// File: rtl/rd73_pkg.sv
// Shared rd73 link definitions: receiver state encoding, default widths and the
// parity function used by both ends of the link.
package rd73_pkg;

  typedef enum logic {RECV, HOLD} rd73_rx_state_t;

  localparam int RD73_DATA_W = 7;
  localparam int RD73_CNT_W  = 3;

  // Even parity: the transmitted parity bit makes the XOR of the whole frame zero.
  function automatic logic rd73_parity(input logic [RD73_DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/rd73_ones_acc.sv
// Running ones-count and parity accumulator for one rd73 frame.
// Data bits feed both the count and the parity; the parity bit feeds parity only.
module rd73_ones_acc
  import rd73_pkg::*;
#(
  parameter int CNT_W = RD73_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             data_en,
  input  logic             par_en,
  input  logic             bit_in,
  output logic [CNT_W-1:0] ones,
  output logic             par
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones <= '0;
      par  <= 1'b0;
    end else if (clr) begin
      ones <= '0;
      par  <= 1'b0;
    end else begin
      if (data_en) ones <= ones + CNT_W'(bit_in);
      if (data_en || par_en) par <= par ^ bit_in;
    end
  end

endmodule

// File: rtl/rd73_serial_parity_checker.sv
// rd73 receiver: deserialises DATA_W data bits plus an even-parity bit, LSB first,
// and presents word, ones-count and parity error over a valid/ready handshake.
module rd73_serial_parity_checker
  import rd73_pkg::*;
#(
  parameter int DATA_W = RD73_DATA_W,
  parameter int CNT_W  = RD73_CNT_W,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_bit,
  input  logic              s_abort,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CNT_W-1:0]  m_ones,
  output logic              m_perr,
  output logic [ERR_W-1:0]  err_cnt,
  input  logic              err_clr
);

  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  rd73_rx_state_t   state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic             bit_acc, last_bit, clr_acc, deliver;

  assign bit_acc  = (state_q == RECV) && s_valid && !s_abort;
  assign last_bit = bit_acc && (idx_q == LAST_IDX);
  assign deliver  = (state_q == HOLD) && m_ready;
  // Abort restarts the frame; a delivered frame frees the accumulators for the next.
  assign clr_acc  = ((state_q == RECV) && s_abort) || deliver;

  assign s_ready = (state_q == RECV);
  assign m_valid = (state_q == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RECV;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RECV:    if (last_bit) state_d = HOLD;
      HOLD:    if (m_ready)  state_d = RECV;
      default: state_d = RECV;
    endcase
  end

  // Bit capture: shift register and index counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      m_data <= '0;
    end else if (clr_acc) begin
      idx_q  <= '0;
      m_data <= '0;
    end else if (bit_acc) begin
      if (last_bit) begin
        idx_q <= '0;
      end else begin
        m_data[idx_q] <= s_bit;
        idx_q         <= idx_q + 1'b1;
      end
    end
  end

  rd73_ones_acc #(.CNT_W(CNT_W)) u_ones_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr_acc),
    .data_en(bit_acc && !last_bit),
    .par_en (last_bit),
    .bit_in (s_bit),
    .ones   (m_ones),
    .par    (m_perr)
  );

  // Delivered-error counter; clear wins over a coincident increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                err_cnt <= '0;
    else if (err_clr)          err_cnt <= '0;
    else if (deliver && m_perr) err_cnt <= sat_inc(err_cnt);
  end

endmodule
